// File: rtl/hazard_scoreboard_unit_pkg.sv
// Shared defaults, producer latency constants and helpers for the hazard scoreboard.
// Optional stall-cycle performance counter is enabled by defining HAZ_PERF_CNT_EN.
package hazard_scoreboard_unit_pkg;

  localparam int DEF_NUM_REGS   = 32;
  localparam int DEF_REG_ADDR_W = 5;
  localparam int DEF_LAT_W      = 4;

  // Cycles until a producer's result can be bypassed into EX.
  localparam int LAT_ALU  = 1;
  localparam int LAT_LOAD = 2;
  localparam int LAT_MUL  = 4;
  localparam int LAT_DIV  = 12;

  function automatic logic [31:0] sat_inc32(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/hazard_sb_entry.sv
// One scoreboard countdown entry: loads a producer latency, counts down to zero,
// and exposes the compares the stall logic needs.
module hazard_sb_entry #(
  parameter int LAT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [LAT_W-1:0] load_val,
  input  logic [LAT_W-1:0] cmp_lat,
  output logic             is_zero,
  output logic             gt1,
  output logic             gt_lat
);

  logic [LAT_W-1:0] cnt_q, cnt_d;

  // A fresh issue overrides the countdown on the same cycle.
  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - LAT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign is_zero = (cnt_q == '0);
  assign gt1     = (cnt_q > LAT_W'(1));
  assign gt_lat  = (cnt_q > cmp_lat);

endmodule

// File: rtl/hazard_scoreboard_unit.sv
// Per-register countdown hazard unit for the MIPS32 ID stage: RAW/WAW stall detection,
// pipeline enables and control-NOP bubble. Define HAZ_PERF_CNT_EN for the stall counter.
module hazard_scoreboard_unit
  import hazard_scoreboard_unit_pkg::*;
#(
  parameter int NUM_REGS   = DEF_NUM_REGS,
  parameter int REG_ADDR_W = DEF_REG_ADDR_W,
  parameter int LAT_W      = DEF_LAT_W
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  id_valid,
  input  logic [REG_ADDR_W-1:0] id_rs,
  input  logic [REG_ADDR_W-1:0] id_rt,
  input  logic                  id_rs_used,
  input  logic                  id_rt_used,
  input  logic                  id_branch,
  input  logic                  id_wr_en,
  input  logic [REG_ADDR_W-1:0] id_wr_reg,
  input  logic [LAT_W-1:0]      id_lat,
  output logic                  stall,
  output logic                  PC_Enable,
  output logic                  IF_ID_Pipeline_Enable,
  output logic                  ID_Control_NOP,
  output logic                  busy_any,
  output logic [31:0]           stall_cycles
);

  logic [NUM_REGS-1:0] nz_vec;
  logic [NUM_REGS-1:0] gt1_vec;
  logic [NUM_REGS-1:0] gtlat_vec;
  logic                raw_rs;
  logic                raw_rt;
  logic                waw;
  logic                wr_nonzero;
  logic                stall_int;
  logic                issue;

  // Register 0 is hard-wired and never holds a pending result.
  assign nz_vec[0]    = 1'b0;
  assign gt1_vec[0]   = 1'b0;
  assign gtlat_vec[0] = 1'b0;

  for (genvar i = 1; i < NUM_REGS; i++) begin : g_entry
    logic zero_w;

    hazard_sb_entry #(
      .LAT_W(LAT_W)
    ) u_entry (
      .clk      (clk),
      .rst      (rst),
      .load     (issue && (id_wr_reg == REG_ADDR_W'(i))),
      .load_val (id_lat),
      .cmp_lat  (id_lat),
      .is_zero  (zero_w),
      .gt1      (gt1_vec[i]),
      .gt_lat   (gtlat_vec[i])
    );

    assign nz_vec[i] = ~zero_w;
  end

  // Branches compare in ID, so they need the value one cycle earlier than EX consumers.
  always_comb begin
    raw_rs     = id_rs_used && (id_branch ? nz_vec[id_rs] : gt1_vec[id_rs]);
    raw_rt     = id_rt_used && (id_branch ? nz_vec[id_rt] : gt1_vec[id_rt]);
    wr_nonzero = (id_wr_reg != '0);
    waw        = id_wr_en && wr_nonzero && gtlat_vec[id_wr_reg];
    stall_int  = id_valid && (raw_rs || raw_rt || waw);
    issue      = id_valid && !stall_int && id_wr_en && wr_nonzero;
  end

  assign stall                 = stall_int;
  assign PC_Enable             = ~stall_int;
  assign IF_ID_Pipeline_Enable = ~stall_int;
  assign ID_Control_NOP        = stall_int;
  assign busy_any              = |nz_vec;

`ifdef HAZ_PERF_CNT_EN
  logic [31:0] stall_cycles_q, stall_cycles_d;

  always_comb begin
    stall_cycles_d = stall_cycles_q;
    if (stall_int) begin
      stall_cycles_d = sat_inc32(stall_cycles_q);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cycles_q <= 32'd0;
    end else begin
      stall_cycles_q <= stall_cycles_d;
    end
  end

  assign stall_cycles = stall_cycles_q;
`else
  assign stall_cycles = 32'd0;
`endif

endmodule

// File: tb/tb_hazard_scoreboard_unit.sv
// Directed self-checking bench for hazard_scoreboard_unit: reset, load-use, branch,
// WAW, r0 and valid qualification, plus the stall counter (HAZ_PERF_CNT_EN aware).
module tb_hazard_scoreboard_unit;
  import hazard_scoreboard_unit_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        id_valid;
  logic [4:0]  id_rs;
  logic [4:0]  id_rt;
  logic        id_rs_used;
  logic        id_rt_used;
  logic        id_branch;
  logic        id_wr_en;
  logic [4:0]  id_wr_reg;
  logic [3:0]  id_lat;
  logic        stall;
  logic        PC_Enable;
  logic        IF_ID_Pipeline_Enable;
  logic        ID_Control_NOP;
  logic        busy_any;
  logic [31:0] stall_cycles;

  int checks = 0;
  int passes = 0;

  hazard_scoreboard_unit dut (
    .clk                   (clk),
    .rst                   (rst),
    .id_valid              (id_valid),
    .id_rs                 (id_rs),
    .id_rt                 (id_rt),
    .id_rs_used            (id_rs_used),
    .id_rt_used            (id_rt_used),
    .id_branch             (id_branch),
    .id_wr_en              (id_wr_en),
    .id_wr_reg             (id_wr_reg),
    .id_lat                (id_lat),
    .stall                 (stall),
    .PC_Enable             (PC_Enable),
    .IF_ID_Pipeline_Enable (IF_ID_Pipeline_Enable),
    .ID_Control_NOP        (ID_Control_NOP),
    .busy_any              (busy_any),
    .stall_cycles          (stall_cycles)
  );

  always #5 clk = ~clk;

  task automatic set_id(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                        input logic rsu, input logic rtu, input logic br,
                        input logic we, input logic [4:0] wr, input logic [3:0] lat);
    id_valid   = v;
    id_rs      = rs;
    id_rt      = rt;
    id_rs_used = rsu;
    id_rt_used = rtu;
    id_branch  = br;
    id_wr_en   = we;
    id_wr_reg  = wr;
    id_lat     = lat;
  endtask

  task automatic idle();
    set_id(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 4'd0);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    idle();
    repeat (16) tick();
  endtask

  task automatic issue_one(input logic [4:0] wr, input int lat);
    set_id(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, wr, 4'(lat));
    tick();
    idle();
  endtask

  // Holds the current ID instruction until it issues; a 20-cycle bound guards against hangs.
  task automatic count_stalls(output int n);
    bit done;
    n = 0;
    done = 1'b0;
    for (int i = 0; i < 20 && !done; i++) begin
      #1;
      if (stall) n++;
      else done = 1'b1;
      tick();
    end
    idle();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle();
    #2;
    checks++; if (stall !== 1'b0) $display("[TB] FAIL reset_stall: got %b expected 0", stall); else passes++;
    checks++; if (PC_Enable !== 1'b1) $display("[TB] FAIL reset_pc_en: got %b expected 1", PC_Enable); else passes++;
    checks++; if (IF_ID_Pipeline_Enable !== 1'b1) $display("[TB] FAIL reset_ifid_en: got %b expected 1", IF_ID_Pipeline_Enable); else passes++;
    checks++; if (ID_Control_NOP !== 1'b0) $display("[TB] FAIL reset_nop: got %b expected 0", ID_Control_NOP); else passes++;
    checks++; if (busy_any !== 1'b0) $display("[TB] FAIL reset_busy: got %b expected 0", busy_any); else passes++;
    checks++; if (stall_cycles !== 32'd0) $display("[TB] FAIL reset_stall_cycles: got %0h expected 0", stall_cycles); else passes++;
    set_id(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd7, 4'd9);
    tick();
    checks++; if (busy_any !== 1'b0) $display("[TB] FAIL reset_hold_busy: got %b expected 0", busy_any); else passes++;
    #3 rst = 1'b0;
    idle();
    tick();
  endtask

  task automatic test_reset_mid_countdown();
    issue_one(5'd4, LAT_DIV);
    tick();
    tick();
    checks++; if (busy_any !== 1'b1) $display("[TB] FAIL div_busy: got %b expected 1", busy_any); else passes++;
    set_id(1'b1, 5'd4, 5'd0, 1'b1, 1'b0, 1'b0, 1'b1, 5'd3, 4'd1);
    #1;
    checks++; if (stall !== 1'b1) $display("[TB] FAIL div_consumer_stall: got %b expected 1", stall); else passes++;
    #2 rst = 1'b1;
    #1;
    checks++; if (stall !== 1'b0) $display("[TB] FAIL async_rst_stall: got %b expected 0", stall); else passes++;
    checks++; if (busy_any !== 1'b0) $display("[TB] FAIL async_rst_busy: got %b expected 0", busy_any); else passes++;
    checks++; if (ID_Control_NOP !== 1'b0) $display("[TB] FAIL async_rst_nop: got %b expected 0", ID_Control_NOP); else passes++;
    idle();
    tick();
    #2 rst = 1'b0;
    tick();
    checks++; if (busy_any !== 1'b0) $display("[TB] FAIL post_rst_busy: got %b expected 0", busy_any); else passes++;
  endtask

  task automatic test_load_use();
    int n;
    issue_one(5'd2, LAT_LOAD);
    set_id(1'b1, 5'd2, 5'd1, 1'b1, 1'b1, 1'b0, 1'b1, 5'd3, 4'(LAT_ALU));
    #1;
    checks++; if (ID_Control_NOP !== 1'b1) $display("[TB] FAIL lw_add_nop: got %b expected 1", ID_Control_NOP); else passes++;
    checks++; if (PC_Enable !== 1'b0) $display("[TB] FAIL lw_add_pc_en: got %b expected 0", PC_Enable); else passes++;
    checks++; if (IF_ID_Pipeline_Enable !== 1'b0) $display("[TB] FAIL lw_add_ifid_en: got %b expected 0", IF_ID_Pipeline_Enable); else passes++;
    count_stalls(n);
    checks++; if (n !== 1) $display("[TB] FAIL lw_add_stalls: got %0d expected 1", n); else passes++;
    // ADD r3 issued with lat 1, so a branch on r3 must stall now.
    set_id(1'b1, 5'd3, 5'd0, 1'b1, 1'b0, 1'b1, 1'b0, 5'd0, 4'd0);
    #1;
    checks++; if (stall !== 1'b1) $display("[TB] FAIL add_issued_r3: got %b expected 1", stall); else passes++;
    drain();
  endtask

  task automatic test_branch();
    int n;
    issue_one(5'd2, LAT_LOAD);
    set_id(1'b1, 5'd2, 5'd0, 1'b1, 1'b1, 1'b1, 1'b0, 5'd0, 4'd0);
    count_stalls(n);
    checks++; if (n !== 2) $display("[TB] FAIL lw_beq_stalls: got %0d expected 2", n); else passes++;
    drain();
    issue_one(5'd5, LAT_ALU);
    set_id(1'b1, 5'd5, 5'd0, 1'b1, 1'b1, 1'b1, 1'b0, 5'd0, 4'd0);
    count_stalls(n);
    checks++; if (n !== 1) $display("[TB] FAIL alu_beq_stalls: got %0d expected 1", n); else passes++;
    drain();
    issue_one(5'd5, LAT_ALU);
    set_id(1'b1, 5'd1, 5'd5, 1'b1, 1'b1, 1'b0, 1'b1, 5'd7, 4'(LAT_ALU));
    count_stalls(n);
    checks++; if (n !== 0) $display("[TB] FAIL alu_add_stalls: got %0d expected 0", n); else passes++;
    drain();
  endtask

  task automatic test_waw();
    int n;
    issue_one(5'd6, LAT_MUL);
    set_id(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd6, 4'(LAT_ALU));
    count_stalls(n);
    checks++; if (n !== 3) $display("[TB] FAIL waw_stalls: got %0d expected 3", n); else passes++;
    set_id(1'b1, 5'd6, 5'd0, 1'b1, 1'b0, 1'b1, 1'b0, 5'd0, 4'd0);
    #1;
    checks++; if (stall !== 1'b1) $display("[TB] FAIL waw_loaded_branch: got %b expected 1", stall); else passes++;
    id_branch = 1'b0;
    #1;
    checks++; if (stall !== 1'b0) $display("[TB] FAIL waw_loaded_alu: got %b expected 0", stall); else passes++;
    idle();
    tick();
    checks++; if (busy_any !== 1'b0) $display("[TB] FAIL waw_drained: got %b expected 0", busy_any); else passes++;
    issue_one(5'd6, LAT_MUL);
    set_id(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd6, 4'(LAT_DIV));
    count_stalls(n);
    checks++; if (n !== 0) $display("[TB] FAIL waw_longer_lat: got %0d expected 0", n); else passes++;
    drain();
    issue_one(5'd8, 0);
    checks++; if (busy_any !== 1'b0) $display("[TB] FAIL lat0_busy: got %b expected 0", busy_any); else passes++;
  endtask

  task automatic test_r0_and_valid();
    issue_one(5'd0, 15);
    checks++; if (busy_any !== 1'b0) $display("[TB] FAIL r0_busy: got %b expected 0", busy_any); else passes++;
    set_id(1'b1, 5'd0, 5'd0, 1'b1, 1'b1, 1'b1, 1'b1, 5'd0, 4'd15);
    #1;
    checks++; if (stall !== 1'b0) $display("[TB] FAIL r0_read_stall: got %b expected 0", stall); else passes++;
    tick();
    checks++; if (busy_any !== 1'b0) $display("[TB] FAIL r0_busy_again: got %b expected 0", busy_any); else passes++;
    issue_one(5'd9, LAT_MUL);
    set_id(1'b0, 5'd9, 5'd9, 1'b1, 1'b1, 1'b1, 1'b1, 5'd9, 4'd1);
    #1;
    checks++; if (stall !== 1'b0) $display("[TB] FAIL invalid_stall: got %b expected 0", stall); else passes++;
    checks++; if (PC_Enable !== 1'b1) $display("[TB] FAIL invalid_pc_en: got %b expected 1", PC_Enable); else passes++;
    checks++; if (busy_any !== 1'b1) $display("[TB] FAIL invalid_busy: got %b expected 1", busy_any); else passes++;
    id_valid = 1'b1;
    #1;
    checks++; if (stall !== 1'b1) $display("[TB] FAIL valid_stall: got %b expected 1", stall); else passes++;
    drain();
  endtask

  task automatic test_perf_counter();
    int n;
    rst = 1'b1;
    #2 rst = 1'b0;
    issue_one(5'd10, 5);
    set_id(1'b1, 5'd10, 5'd0, 1'b1, 1'b0, 1'b1, 1'b0, 5'd0, 4'd0);
    count_stalls(n);
    checks++; if (n !== 5) $display("[TB] FAIL perf_stalls: got %0d expected 5", n); else passes++;
`ifdef HAZ_PERF_CNT_EN
    checks++; if (stall_cycles !== 32'd5) $display("[TB] FAIL perf_count: got %0h expected 5", stall_cycles); else passes++;
    force dut.stall_cycles_q = 32'hFFFF_FFFF;
    #1 release dut.stall_cycles_q;
    issue_one(5'd11, LAT_ALU);
    set_id(1'b1, 5'd11, 5'd0, 1'b1, 1'b0, 1'b1, 1'b0, 5'd0, 4'd0);
    count_stalls(n);
    checks++; if (stall_cycles !== 32'hFFFF_FFFF) $display("[TB] FAIL perf_saturate: got %0h expected ffffffff", stall_cycles); else passes++;
`else
    checks++; if (stall_cycles !== 32'd0) $display("[TB] FAIL perf_disabled: got %0h expected 0", stall_cycles); else passes++;
`endif
    drain();
  endtask

  initial begin
    test_reset();
    test_reset_mid_countdown();
    test_load_use();
    test_branch();
    test_waw();
    test_r0_and_valid();
    test_perf_counter();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
